rv32i_fetch: RTL and testbench
==============================

Name: rv32i_fetch

Overview:
- Instruction fetch stage directly upstream of the RV32I datapath. Owns the program counter.
- Issues word requests to instruction memory and tracks one outstanding request.
- Presents the returned instruction plus its PC to the datapath through a valid/ready hold register.
- Handles branch/jump redirects, including squashing in-flight responses, and flags misaligned targets.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP, 32'h0000_0013, value driven on inst when no valid instruction is held (addi x0,x0,0)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous active-high reset
- imem_req  output  1  request strobe; memory accepts the request in the cycle it is high
- imem_addr  output  32  word address of the request (always equal to pc)
- imem_rvalid  input  1  response valid, earliest one cycle after imem_req
- imem_rdata  input  32  response instruction word
- redirect  input  1  branch/jump taken, from the datapath
- redirect_pc  input  32  redirect target
- inst_valid  output  1  inst/inst_pc hold a live instruction
- inst_ready  input  1  datapath consumes the instruction this cycle
- inst  output  32  instruction to the datapath; NOP when inst_valid=0
- inst_pc  output  32  PC of inst
- fault  output  1  sticky misaligned-redirect fault
- inst_count  output  32  number of retired (consumed) instructions, wraps modulo 2^32

Behaviour:
- Reset (async, any state, including with a request outstanding):
  - pc=RESET_PC, state=REQ, kill=0
  - inst_valid=0, inst=NOP, inst_pc=RESET_PC
  - fault=0, inst_count=0
  - Any response arriving after reset deasserts is ignored until a request has been issued.
- States: REQ, WAIT, HOLD, HALT.
- imem_req=1 only in state REQ (combinational from state). imem_addr=pc in all states.
- REQ:
  - Request issued this cycle; next state WAIT.
  - If redirect=1 in the same cycle: pc<=redirect_pc, kill<=1.
- WAIT:
  - imem_rvalid=0: stay. If redirect=1: pc<=redirect_pc, kill<=1.
  - imem_rvalid=1 and (kill=1 or redirect=1): drop data, kill<=0, go to REQ. On redirect, also pc<=redirect_pc.
  - imem_rvalid=1, kill=0, redirect=0: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, go to HOLD.
  - imem_rvalid while in REQ/HOLD/HALT is a protocol error and is ignored.
- HOLD:
  - inst, inst_pc and inst_valid remain stable until consumed.
  - redirect=1 has priority over inst_ready: pc<=redirect_pc, inst_valid<=0, inst<=NOP, go to REQ. inst_count is unchanged.
  - inst_ready=1, redirect=0: pc<=pc+4 (wraps 32'hFFFF_FFFC->0), inst_valid<=0, inst<=NOP, inst_count<=inst_count+1, go to REQ.
- Misaligned redirect: any accepted redirect with redirect_pc[1:0]!=0:
  - fault<=1; pc still loads the target; next state HALT.
  - In HALT: no requests, inst_valid=0, further redirects ignored. Only reset exits.
  - A response still outstanding on entry to HALT is ignored.
- Throughput: 3 cycles per instruction minimum (REQ, WAIT with immediate rvalid, HOLD with ready). Memory latency adds cycles in WAIT.
- At most one outstanding request at any time. kill guarantees a squashed response is never presented to the datapath.

Test Plan:
- Reset then run: RESET_PC=0, memory latency 1, inst_ready tied 1, mem[0]=0x00500093, mem[4]=0x00A00113 -> inst_valid with inst_pc=0 then inst_pc=4, imem_req period of 3 cycles, inst_count=2 after the second consumption.
- Backpressure: inst_ready=0 for 5 cycles in HOLD -> inst/inst_pc stable, no imem_req, inst_count unchanged; inst_ready=1 -> pc advances by 4, new request the next cycle.
- Redirect in WAIT with 3-cycle latency: redirect_pc=0x100 one cycle after a request to 0x8 -> response for 0x8 dropped, next request to 0x100, first presented inst_pc=0x100.
- Redirect and inst_ready together in HOLD at pc 0x20, redirect_pc=0x40 -> inst_count not incremented, next request to 0x40.
- Misaligned redirect 0x102 -> fault=1, imem_req stays 0 and inst_valid stays 0 thereafter; a later redirect to 0x200 is ignored; reset clears fault and restarts fetch at RESET_PC.
- Async reset asserted mid-WAIT, followed by a late imem_rvalid -> outputs at reset values immediately, late response discarded, fetch restarts at RESET_PC. Also: pc=0xFFFFFFFC consumed -> next request to 0x0.

Source files
------------

// File: rtl/rv32i_fetch.sv
// Purpose : RV32I instruction fetch stage; owns the PC, issues one word request at a
//           time to instruction memory, and hands the returned instruction to the datapath.
// Latency : min 3 cycles per instruction (REQ, WAIT with immediate rvalid, HOLD with ready).
// Backpressure: the instruction is held stable in HOLD until inst_ready; no request is issued meanwhile.
//
// Ports:
//   clk, reset                 - rising-edge clock, asynchronous active-high reset
//   imem_req / imem_addr       - request strobe (accepted the cycle it is high) and word address (= pc)
//   imem_rvalid / imem_rdata   - instruction memory response
//   redirect / redirect_pc     - taken branch/jump target from the datapath
//   inst_valid / inst_ready    - hold-register handshake towards the datapath
//   inst / inst_pc             - held instruction (NOP when not valid) and its PC
//   fault                      - sticky misaligned-redirect flag; fetch halts until reset
//   inst_count                 - count of consumed instructions, wraps modulo 2^32
module rv32i_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fault,
    output logic [31:0] inst_count
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_kill;
    logic        r_inst_valid;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_fault;
    logic [31:0] r_inst_count;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_kill_nxt;
    logic        w_inst_valid_nxt;
    logic [31:0] w_inst_nxt;
    logic [31:0] w_inst_pc_nxt;
    logic        w_fault_nxt;
    logic [31:0] w_inst_count_nxt;
    logic        w_misaligned;

    assign w_misaligned = (redirect_pc[1:0] != 2'b00);

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_kill_nxt       = r_kill;
        w_inst_valid_nxt = r_inst_valid;
        w_inst_nxt       = r_inst;
        w_inst_pc_nxt    = r_inst_pc;
        w_fault_nxt      = r_fault;
        w_inst_count_nxt = r_inst_count;

        case (r_state)
            S_REQ: begin
                w_state_nxt = S_WAIT;
                if (redirect) begin
                    w_pc_nxt = redirect_pc;
                    if (w_misaligned) begin
                        // The request just issued will answer into HALT, where rvalid is ignored.
                        w_fault_nxt = 1'b1;
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = S_HALT;
                    end else begin
                        // Response for the old pc is already on its way; mark it for dropping.
                        w_kill_nxt = 1'b1;
                    end
                end
            end

            S_WAIT: begin
                if (redirect) begin
                    w_pc_nxt = redirect_pc;
                    if (w_misaligned) begin
                        w_fault_nxt = 1'b1;
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = S_HALT;
                    end else if (imem_rvalid) begin
                        // Stale data arriving with the redirect is dropped and the new pc fetched.
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_kill_nxt = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (r_kill) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_inst_nxt       = imem_rdata;
                        w_inst_pc_nxt    = r_pc;
                        w_inst_valid_nxt = 1'b1;
                        w_state_nxt      = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                // Redirect wins over consumption: the held instruction is on the wrong path.
                if (redirect) begin
                    w_pc_nxt         = redirect_pc;
                    w_inst_valid_nxt = 1'b0;
                    w_inst_nxt       = NOP;
                    if (w_misaligned) begin
                        w_fault_nxt = 1'b1;
                        w_state_nxt = S_HALT;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end else if (inst_ready) begin
                    w_pc_nxt         = r_pc + 32'd4;
                    w_inst_valid_nxt = 1'b0;
                    w_inst_nxt       = NOP;
                    w_inst_count_nxt = r_inst_count + 32'd1;
                    w_state_nxt      = S_REQ;
                end
            end

            S_HALT: begin
                // Terminal until reset: redirects and responses are ignored.
            end

            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_kill       <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= NOP;
            r_inst_pc    <= RESET_PC;
            r_fault      <= 1'b0;
            r_inst_count <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_kill       <= w_kill_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_inst       <= w_inst_nxt;
            r_inst_pc    <= w_inst_pc_nxt;
            r_fault      <= w_fault_nxt;
            r_inst_count <= w_inst_count_nxt;
        end
    end

    assign imem_req   = (r_state == S_REQ);
    assign imem_addr  = r_pc;
    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign fault      = r_fault;
    assign inst_count = r_inst_count;

endmodule

// File: tb/tb_rv32i_fetch.sv
// Purpose : directed self-checking bench for rv32i_fetch with a behavioural instruction memory.
// Latency : memory answers m_lat cycles after the cycle in which imem_req is seen.
// Backpressure: inst_ready driven directly by the stimulus sequence.
module tb_rv32i_fetch;

    localparam logic [31:0] NOP_W = 32'h0000_0013;
    localparam logic [31:0] BAD_W = 32'hBAD0_BAD0;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fault;
    logic [31:0] inst_count;

    int          n_checks;
    int          n_fail;

    // memory model state
    int          m_lat;
    int          m_cnt;
    logic [31:0] m_addr;

    rv32i_fetch #(
        .RESET_PC(32'h0000_0000),
        .NOP     (32'h0000_0013)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .fault      (fault),
        .inst_count (inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_rd = 32'h0050_0093;
            32'h0000_0004: mem_rd = 32'h00A0_0113;
            default:       mem_rd = 32'h1000_0000 ^ a;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One clock: memory latches any request presented this cycle, then the edge,
    // then the response (if due) is driven for the new cycle. Outputs are checked
    // 1 time unit after the edge.
    task automatic tick();
        if (imem_req && !reset) begin
            m_cnt  = m_lat;
            m_addr = imem_addr;
        end
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_rd(m_addr);
            end
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        m_lat       = 1;
        m_cnt       = 0;
        m_addr      = 32'h0;
        reset       = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, NOP_W);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_count", inst_count, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        reset = 1'b0;

        // ---------------- basic run, latency 1, ready=1 ----------------
        inst_ready = 1'b1;
        check("run_req0", {31'd0, imem_req}, 32'd1);
        tick();                                        // WAIT
        check("run_wait_req", {31'd0, imem_req}, 32'd0);
        tick();                                        // HOLD
        check("run_v0", {31'd0, inst_valid}, 32'd1);
        check("run_inst0", inst, 32'h0050_0093);
        check("run_pc0", inst_pc, 32'h0);
        tick();                                        // REQ pc=4
        check("run_req1", {31'd0, imem_req}, 32'd1);
        check("run_addr1", imem_addr, 32'h4);
        check("run_cnt1", inst_count, 32'd1);
        check("run_nop", inst, NOP_W);
        tick();
        tick();
        check("run_inst1", inst, 32'h00A0_0113);
        check("run_pc1", inst_pc, 32'h4);
        tick();                                        // REQ pc=8
        check("run_cnt2", inst_count, 32'd2);
        check("run_addr2", imem_addr, 32'h8);

        // ---------------- redirect in WAIT, latency 3 ----------------
        m_lat = 3;
        tick();                                        // WAIT, request to 0x8 outstanding
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        check("rw_addr", imem_addr, 32'h100);
        check("rw_req", {31'd0, imem_req}, 32'd0);
        tick();                                        // stale rvalid for 0x8 this cycle
        check("rw_rvalid_seen", {31'd0, imem_rvalid}, 32'd1);
        tick();                                        // dropped, back to REQ
        check("rw_drop_valid", {31'd0, inst_valid}, 32'd0);
        check("rw_req2", {31'd0, imem_req}, 32'd1);
        check("rw_addr2", imem_addr, 32'h100);
        inst_ready = 1'b0;
        tick();
        tick();
        tick();
        tick();                                        // HOLD
        check("rw_valid", {31'd0, inst_valid}, 32'd1);
        check("rw_inst_pc", inst_pc, 32'h100);
        check("rw_inst", inst, 32'h1000_0100);

        // ---------------- backpressure ----------------
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", {31'd0, inst_valid}, 32'd1);
            check("bp_req", {31'd0, imem_req}, 32'd0);
            check("bp_pc", inst_pc, 32'h100);
        end
        check("bp_inst", inst, 32'h1000_0100);
        check("bp_cnt", inst_count, 32'd2);
        inst_ready = 1'b1;
        tick();
        check("bp_req_after", {31'd0, imem_req}, 32'd1);
        check("bp_addr_after", imem_addr, 32'h104);
        check("bp_cnt_after", inst_count, 32'd3);

        // ---------------- redirect + ready together in HOLD ----------------
        m_lat       = 1;
        redirect    = 1'b1;
        redirect_pc = 32'h20;                          // redirect in REQ
        tick();
        redirect = 1'b0;
        tick();                                        // killed response dropped
        check("rh_addr20", imem_addr, 32'h20);
        check("rh_req20", {31'd0, imem_req}, 32'd1);
        check("rh_nohold", {31'd0, inst_valid}, 32'd0);
        tick();
        tick();                                        // HOLD at 0x20
        check("rh_pc20", inst_pc, 32'h20);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        check("rh_cnt", inst_count, 32'd3);
        check("rh_addr40", imem_addr, 32'h40);
        check("rh_req40", {31'd0, imem_req}, 32'd1);
        check("rh_valid", {31'd0, inst_valid}, 32'd0);
        check("rh_nop", inst, NOP_W);

        // ---------------- pc wrap ----------------
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        tick();
        check("wr_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        tick();
        check("wr_inst_pc", inst_pc, 32'hFFFF_FFFC);
        tick();
        check("wr_addr0", imem_addr, 32'h0);
        check("wr_req0", {31'd0, imem_req}, 32'd1);
        check("wr_cnt", inst_count, 32'd4);

        // ---------------- misaligned redirect ----------------
        tick();                                        // WAIT, rvalid present
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
        check("ma_fault", {31'd0, fault}, 32'd1);
        check("ma_addr", imem_addr, 32'h102);
        check("ma_req", {31'd0, imem_req}, 32'd0);
        check("ma_valid", {31'd0, inst_valid}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        check("ma_ignore", imem_addr, 32'h102);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ma_halt_req", {31'd0, imem_req}, 32'd0);
            check("ma_halt_valid", {31'd0, inst_valid}, 32'd0);
        end
        check("ma_cnt", inst_count, 32'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("ma_rst_fault", {31'd0, fault}, 32'd0);
        check("ma_rst_addr", imem_addr, 32'h0);
        check("ma_rst_req", {31'd0, imem_req}, 32'd1);

        // ---------------- async reset mid-WAIT ----------------
        tick();
        tick();
        tick();                                        // consumed, pc=4 count=1
        check("ar_cnt1", inst_count, 32'd1);
        m_lat = 3;
        tick();                                        // WAIT on 0x4
        tick();
        #2;
        reset = 1'b1;                                  // between edges
        #1;
        check("ar_req", {31'd0, imem_req}, 32'd1);
        check("ar_addr", imem_addr, 32'h0);
        check("ar_cnt", inst_count, 32'd0);
        check("ar_valid", {31'd0, inst_valid}, 32'd0);
        m_cnt = 0;                                     // memory abandons the old request
        tick();
        reset       = 1'b0;
        m_lat       = 1;
        imem_rvalid = 1'b1;                            // late response while in REQ
        imem_rdata  = BAD_W;
        tick();                                        // WAIT with real response
        tick();                                        // HOLD
        check("ar_inst", inst, 32'h0050_0093);
        check("ar_inst_pc", inst_pc, 32'h0);
        check("ar_hold_valid", {31'd0, inst_valid}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
